// File: rtl/multicycle_alu_if.sv
// Operation request / result bundle shared by the ALU and whatever drives it.
// Master issues Start/operands; slave reports Busy/Done/Result/ALUFlags.
interface multicycle_alu_if #(
  parameter int WIDTH = 32
);
  logic             Start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [2:0]       ALUControl;
  logic             Busy;
  logic             Done;
  logic [WIDTH-1:0] Result;
  logic [3:0]       ALUFlags;

  modport master (
    output Start, A, B, ALUControl,
    input  Busy, Done, Result, ALUFlags
  );

  modport slave (
    input  Start, A, B, ALUControl,
    output Busy, Done, Result, ALUFlags
  );
endinterface

// File: rtl/multicycle_alu.sv
// ALU with single-cycle logic/add/sub ops and a WIDTH-cycle shift-add multiplier.
// Result and {N,Z,C,V} are registered and only change on a Done pulse.
module multicycle_alu #(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RESETn,
  multicycle_alu_if.slave  bus
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_ORR = 3'b011;
  localparam logic [2:0] OP_EOR = 3'b100;
  localparam logic [2:0] OP_MOV = 3'b101;
  localparam logic [2:0] OP_MUL = 3'b110;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_nxt;
  logic [WIDTH-1:0] result_q;
  logic [3:0]       flags_q;
  logic             done_q;
  logic             accept;
  logic             mul_last;
  logic [WIDTH+3:0] single_res;

  function automatic logic [1:0] nz_of(input logic [WIDTH-1:0] r);
    return {r[WIDTH-1], (r == '0)};
  endfunction

  // Returns {N,Z,C,V,result}. ADD and SUB share one adder; SUB inverts B and carries in 1.
  function automatic logic [WIDTH+3:0] single_op(
    input logic [WIDTH-1:0] a,
    input logic [WIDTH-1:0] b,
    input logic [2:0]       op
  );
    logic [WIDTH-1:0] b_in;
    logic [WIDTH-1:0] res;
    logic [WIDTH:0]   sum;
    logic             c;
    logic             v;
    logic             is_sub;
    is_sub = (op == OP_SUB);
    b_in   = is_sub ? ~b : b;
    sum    = {1'b0, a} + {1'b0, b_in} + {{WIDTH{1'b0}}, is_sub};
    c      = 1'b0;
    v      = 1'b0;
    case (op)
      OP_AND:  res = a & b;
      OP_ORR:  res = a | b;
      OP_EOR:  res = a ^ b;
      OP_MOV:  res = b;
      default: begin
        res = sum[WIDTH-1:0];
        c   = sum[WIDTH];
        v   = (a[WIDTH-1] == b_in[WIDTH-1]) && (res[WIDTH-1] != a[WIDTH-1]);
      end
    endcase
    return {nz_of(res), c, v, res};
  endfunction

  assign accept     = (state == ST_IDLE) && bus.Start;
  assign mul_last   = (state == ST_MUL) && (cnt == LAST);
  assign acc_nxt    = mplier[0] ? (acc + mcand) : acc;
  assign single_res = single_op(bus.A, bus.B, bus.ALUControl);

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (bus.Start && (bus.ALUControl == OP_MUL)) state_nxt = ST_MUL;
      ST_MUL:  if (cnt == LAST) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Datapath: operand capture, shift-add iterations and result/flag registers
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      cnt      <= '0;
      mcand    <= '0;
      mplier   <= '0;
      acc      <= '0;
      result_q <= '0;
      flags_q  <= '0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (accept) begin
        if (bus.ALUControl == OP_MUL) begin
          mcand  <= bus.A;
          mplier <= bus.B;
          acc    <= '0;
          cnt    <= '0;
        end else begin
          result_q <= single_res[WIDTH-1:0];
          flags_q  <= single_res[WIDTH+3:WIDTH];
          done_q   <= 1'b1;
        end
      end else if (state == ST_MUL) begin
        acc    <= acc_nxt;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        cnt    <= cnt + CNT_W'(1);
        if (mul_last) begin
          result_q <= acc_nxt;
          flags_q  <= {nz_of(acc_nxt), 2'b00};
          done_q   <= 1'b1;
        end
      end
    end
  end

  assign bus.Busy     = (state == ST_MUL);
  assign bus.Done     = done_q;
  assign bus.Result   = result_q;
  assign bus.ALUFlags = flags_q;

endmodule
